// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring) over 32 iteration
// cycles, serves MFHI/MFLO/MTHI/MTLO, and stalls the front of the pipeline while an
// operation is running.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   - DIV/DIVU implemented.
//   undefined - divider datapath and DIV state omitted; DIV/DIVU act as no-ops.
//
// Ports:
//   CLK          in   pipeline clock, rising edge
//   RESET        in   asynchronous active-high reset
//   EX_Opcode    in   [5:0]  opcode of instruction in EX
//   EX_Funct     in   [5:0]  funct field of instruction in EX
//   EX_RS_Data   in   [31:0] rs operand (multiplicand / dividend / MTHI-MTLO source)
//   EX_RT_Data   in   [31:0] rt operand (multiplier / divisor)
//   EX_Flush     in   EX slot is a bubble; blocks new starts and HI/LO writes
//   MD_Stall     out  hold IF/ID, ID/EX and PC
//   MD_Busy      out  iteration in progress
//   MD_HILO_Data out  [31:0] HI for MFHI, LO for MFLO, else 0
//   MD_HI        out  [31:0] current HI
//   MD_LO        out  [31:0] current LO
module ex_muldiv_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  EX_Opcode,
  input  logic [5:0]  EX_Funct,
  input  logic [31:0] EX_RS_Data,
  input  logic [31:0] EX_RT_Data,
  input  logic        EX_Flush,
  output logic        MD_Stall,
  output logic        MD_Busy,
  output logic [31:0] MD_HILO_Data,
  output logic [31:0] MD_HI,
  output logic [31:0] MD_LO
);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
`ifdef MULDIV_DIV_EN
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;     // product accumulator; [63:32] doubles as divide remainder
  logic [31:0] op_a_q, op_a_d;   // |rs|; shifts into the quotient while dividing
  logic [31:0] op_b_q, op_b_d;   // |rt|; shifts right while multiplying
  logic        neg_q, neg_d;     // product / quotient sign
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Decode. RESET also blocks decode so no stall or start is seen during reset.
  logic dec_valid, is_mul, is_div, start, is_signed;
  logic [31:0] rs_abs, rt_abs;

  assign dec_valid = !RESET && (EX_Opcode == 6'h00) && !EX_Flush;
  assign is_mul    = dec_valid && ((EX_Funct == FnMult) || (EX_Funct == FnMultu));
`ifdef MULDIV_DIV_EN
  assign is_div    = dec_valid && ((EX_Funct == FnDiv) || (EX_Funct == FnDivu));
`else
  assign is_div    = 1'b0;
`endif
  assign start     = is_mul || is_div;
  // MULT and DIV have funct[0]=0, the unsigned variants funct[0]=1.
  assign is_signed = !EX_Funct[0];
  assign rs_abs    = (is_signed && EX_RS_Data[31]) ? (32'd0 - EX_RS_Data) : EX_RS_Data;
  assign rt_abs    = (is_signed && EX_RT_Data[31]) ? (32'd0 - EX_RT_Data) : EX_RT_Data;

  // Multiply step: add multiplicand into the upper half, then shift the whole
  // accumulator right; after 32 steps it holds the full 64-bit product.
  logic [32:0] mul_sum;
  logic [63:0] mul_acc, mul_res;

  assign mul_sum = {1'b0, acc_q[63:32]} + (op_b_q[0] ? {1'b0, op_a_q} : 33'd0);
  assign mul_acc = {mul_sum, acc_q[31:1]};
  assign mul_res = neg_q ? (64'd0 - mul_acc) : mul_acc;

`ifdef MULDIV_DIV_EN
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] rs_raw_q, rs_raw_d;   // untouched rs, returned in HI on divide-by-zero
  logic [32:0] rem_shift, rem_diff;
  logic        q_bit;
  logic [31:0] rem_nxt, quo_nxt;

  // Restoring step: remainder < divisor always, so the shifted value fits 33 bits.
  assign rem_shift = {acc_q[63:32], op_a_q[31]};
  assign rem_diff  = rem_shift - {1'b0, op_b_q};
  assign q_bit     = !rem_diff[32];
  assign rem_nxt   = q_bit ? rem_diff[31:0] : rem_shift[31:0];
  assign quo_nxt   = {op_a_q[30:0], q_bit};
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (is_mul) begin
          state_d = StMul;
`ifdef MULDIV_DIV_EN
        end else if (is_div) begin
          state_d = StDiv;
`endif
        end
      end
      StMul:   if (count_q == 5'd31) state_d = StDone;
`ifdef MULDIV_DIV_EN
      StDiv:   if (count_q == 5'd31) state_d = StDone;
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    MD_Busy = (state_q == StMul);
`ifdef MULDIV_DIV_EN
    MD_Busy = MD_Busy || (state_q == StDiv);
`endif
    MD_Stall     = MD_Busy || ((state_q == StIdle) && start);
    MD_HILO_Data = 32'd0;
    if (dec_valid && (state_q == StIdle)) begin
      if (EX_Funct == FnMfhi) MD_HILO_Data = hi_q;
      if (EX_Funct == FnMflo) MD_HILO_Data = lo_q;
    end
  end

  assign MD_HI = hi_q;
  assign MD_LO = lo_q;

  // Datapath next state
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    rem_neg_d = rem_neg_q;
    rs_raw_d  = rs_raw_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d  = rs_abs;
          op_b_d  = rt_abs;
          neg_d   = is_signed && (EX_RS_Data[31] ^ EX_RT_Data[31]);
          acc_d   = 64'd0;
          count_d = 5'd0;
`ifdef MULDIV_DIV_EN
          rem_neg_d = is_signed && EX_RS_Data[31];
          rs_raw_d  = EX_RS_Data;
`endif
        end else if (dec_valid && (EX_Funct == FnMthi)) begin
          hi_d = EX_RS_Data;
        end else if (dec_valid && (EX_Funct == FnMtlo)) begin
          lo_d = EX_RS_Data;
        end
      end
      StMul: begin
        acc_d   = mul_acc;
        op_b_d  = {1'b0, op_b_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          hi_d = mul_res[63:32];
          lo_d = mul_res[31:0];
        end
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        acc_d[63:32] = rem_nxt;
        op_a_d       = quo_nxt;
        count_d      = count_q + 5'd1;
        if (count_q == 5'd31) begin
          if (op_b_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = rs_raw_q;
          end else begin
            lo_d = neg_q ? (32'd0 - quo_nxt) : quo_nxt;
            hi_d = rem_neg_q ? (32'd0 - rem_nxt) : rem_nxt;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= 5'd0;
      acc_q   <= 64'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rem_neg_q <= 1'b0;
      rs_raw_q  <= 32'd0;
    end else begin
      rem_neg_q <= rem_neg_d;
      rs_raw_q  <= rs_raw_d;
    end
  end
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [5:0]  EX_Opcode;
  logic [5:0]  EX_Funct;
  logic [31:0] EX_RS_Data;
  logic [31:0] EX_RT_Data;
  logic        EX_Flush;
  logic        MD_Stall;
  logic        MD_Busy;
  logic [31:0] MD_HILO_Data;
  logic [31:0] MD_HI;
  logic [31:0] MD_LO;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural model of HI/LO.
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  ex_muldiv_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EX_Opcode    (EX_Opcode),
    .EX_Funct     (EX_Funct),
    .EX_RS_Data   (EX_RS_Data),
    .EX_RT_Data   (EX_RT_Data),
    .EX_Flush     (EX_Flush),
    .MD_Stall     (MD_Stall),
    .MD_Busy      (MD_Busy),
    .MD_HILO_Data (MD_HILO_Data),
    .MD_HI        (MD_HI),
    .MD_LO        (MD_LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    EX_Opcode  = op;
    EX_Funct   = fn;
    EX_RS_Data = rs;
    EX_RT_Data = rt;
    EX_Flush   = fl;
  endtask

  // Reference results as {HI, LO}, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [5:0] fn, input logic [31:0] rs,
                                          input logic [31:0] rt);
    longint a, b;
    if (fn == FN_MULT) begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
    end else begin
      a = longint'({32'd0, rs});
      b = longint'({32'd0, rt});
    end
    return 64'(a * b);
  endfunction

  function automatic logic [63:0] ref_div(input logic [5:0] fn, input logic [31:0] rs,
                                          input logic [31:0] rt);
    longint a, b, q, r;
    if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
    if (fn == FN_DIV) begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
    end else begin
      a = longint'({32'd0, rs});
      b = longint'({32'd0, rt});
    end
    q = a / b;
    r = a % b;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one multiply/divide and follow it to DONE.
  task automatic run_md(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] r;
    int cyc;
    if ((fn == FN_MULT) || (fn == FN_MULTU)) r = ref_mul(fn, rs, rt);
    else r = ref_div(fn, rs, rt);
    @(negedge CLK);
    drive(6'h00, fn, rs, rt, 1'b0);
    #1;
    check("start_busy", {63'd0, MD_Busy}, 64'd0);
    cyc = 0;
    while (MD_Stall && (cyc < 100)) begin
      cyc++;
      @(negedge CLK);
      #1;
      // A bubble marker during iteration must not disturb the operation.
      if (MD_Busy) EX_Flush = 1'($urandom_range(0, 1));
    end
    check("stall_cycles", 64'(cyc), 64'd33);
    check("done_busy", {63'd0, MD_Busy}, 64'd0);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check("result_hilo", {MD_HI, MD_LO}, r);
    drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check_reads();
    @(negedge CLK);
    drive(6'h00, FN_MFHI, $urandom, $urandom, 1'b0);
    #1;
    check("mfhi_data", {32'd0, MD_HILO_Data}, {32'd0, exp_hi});
    check("mfhi_stall", {63'd0, MD_Stall}, 64'd0);
    EX_Funct = FN_MFLO;
    #1;
    check("mflo_data", {32'd0, MD_HILO_Data}, {32'd0, exp_lo});
    EX_Funct = FN_ADD;
    #1;
    check("other_data", {32'd0, MD_HILO_Data}, 64'd0);
  endtask

  initial begin
    logic [5:0]  fn;
    logic [31:0] rs, rt;

    RESET = 1'b1;
    drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #2;
    check("reset_outputs", {28'd0, MD_Stall, MD_Busy, 2'd0, MD_HILO_Data},
          64'd0);
    check("reset_hilo", {MD_HI, MD_LO}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Directed multiplies
    run_md(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {MD_HI, MD_LO}, 64'hFFFF_FFFE_0000_0001);
    run_md(FN_MULT, 32'hFFFF_FFF9, 32'd3);
    check("mult_neg", {MD_HI, MD_LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    check_reads();

    // MTLO then MFLO: forwarded next cycle, never stalls
    @(negedge CLK);
    drive(6'h00, FN_MTLO, 32'h1234_5678, 32'd0, 1'b0);
    #1;
    check("mtlo_stall", {63'd0, MD_Stall}, 64'd0);
    @(negedge CLK);
    drive(6'h00, FN_MFLO, 32'd0, 32'd0, 1'b0);
    #1;
    exp_lo = 32'h1234_5678;
    check("mflo_after_mtlo", {32'd0, MD_HILO_Data}, 64'h1234_5678);
    check("mflo_stall", {63'd0, MD_Stall}, 64'd0);

    // Flushed slot: no start, no HI write
    @(negedge CLK);
    drive(6'h00, FN_MULT, 32'd5, 32'd5, 1'b1);
    #1;
    check("flush_no_stall", {63'd0, MD_Stall}, 64'd0);
    EX_Funct = FN_MTHI;
    @(negedge CLK);
    #1;
    check("flush_no_mthi", {32'd0, MD_HI}, {32'd0, exp_hi});
    drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);

`ifdef MULDIV_DIV_EN
    run_md(FN_DIV, 32'hFFFF_FFEF, 32'd5);
    check("div_neg", {MD_HI, MD_LO}, 64'hFFFF_FFFE_FFFF_FFFD);
    run_md(FN_DIVU, 32'd100, 32'd0);
    check("divu_zero", {MD_HI, MD_LO}, {32'd100, 32'hFFFF_FFFF});
    run_md(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {MD_HI, MD_LO}, {32'd0, 32'h8000_0000});
    run_md(FN_DIV, 32'hFFFF_FFF0, 32'd0);
    check_reads();
`else
    // Divide omitted: DIV is a no-op
    @(negedge CLK);
    drive(6'h00, FN_DIV, 32'd10, 32'd2, 1'b0);
    #1;
    check("nodiv_stall", {63'd0, MD_Stall}, 64'd0);
    repeat (3) @(negedge CLK);
    #1;
    check("nodiv_busy", {63'd0, MD_Busy}, 64'd0);
    check("nodiv_hilo", {MD_HI, MD_LO}, {exp_hi, exp_lo});
    drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);
`endif

    // Reset in the middle of a multiply
    @(negedge CLK);
    drive(6'h00, FN_MULT, 32'h1234, 32'h5678, 1'b0);
    repeat (10) @(negedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("rst_mid_ctrl", {62'd0, MD_Stall, MD_Busy}, 64'd0);
    check("rst_mid_hilo", {MD_HI, MD_LO}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    run_md(FN_MULT, 32'd6, 32'd7);
    check("mult_after_rst", {32'd0, MD_LO}, 64'd42);

    // Randomized operations and moves against the model
    for (int i = 0; i < 10; i++) begin
      rs = $urandom;
      rt = $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 1000));
`ifdef MULDIV_DIV_EN
      case ($urandom_range(0, 3))
        0: fn = FN_MULT;
        1: fn = FN_MULTU;
        2: fn = FN_DIV;
        default: fn = FN_DIVU;
      endcase
`else
      fn = ($urandom_range(0, 1) == 0) ? FN_MULT : FN_MULTU;
`endif
      run_md(fn, rs, rt);
      @(negedge CLK);
      rs = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        drive(6'h00, FN_MTHI, rs, 32'd0, 1'b0);
        exp_hi = rs;
      end else begin
        drive(6'h00, FN_MTLO, rs, 32'd0, 1'b0);
        exp_lo = rs;
      end
      @(negedge CLK);
      drive(6'h00, 6'h00, 32'd0, 32'd0, 1'b0);
      #1;
      check("rand_move", {MD_HI, MD_LO}, {exp_hi, exp_lo});
      check_reads();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
